// File: rtl/msx_audio_mixer.sv
// -----------------------------------------------------------------------------
// msx_audio_mixer
//
// Time-multiplexed audio mixer. One request on ce_sample mixes every source
// channel through a single shared multiply-accumulate, one channel per clock.
// It then applies master volume, saturates to OUT_W bits, and presents the
// result as a registered sample.
//
// The sequence is IDLE -> ACCUM (CHANNELS clocks) -> MASTER -> SAT -> IDLE.
// A request accepted in cycle t gives audio_valid in cycle t+CHANNELS+3.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   ce_sample    sample request strobe, one clk wide
//   ch_data      channel samples, channel k at [k*IN_W +: IN_W]
//   ch_signed    per channel: 1 = two's complement, 0 = unsigned
//   ch_vol       per-channel volume, unsigned, 8 = unity
//   ch_mute      per channel: 1 = contributes nothing
//   master_vol   master volume, unsigned, 8 = unity
//   audio_out    signed mixed sample, held between updates
//   audio_valid  one-clk pulse when audio_out updates
//   clip         last sample was saturated; held with audio_out
//   busy         mix in progress
//   overrun      one-clk pulse: a request arrived while busy and was dropped
// -----------------------------------------------------------------------------
module msx_audio_mixer #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_sample,
  input  logic [CHANNELS*IN_W-1:0]  ch_data,
  input  logic [CHANNELS-1:0]       ch_signed,
  input  logic [CHANNELS*VOL_W-1:0] ch_vol,
  input  logic [CHANNELS-1:0]       ch_mute,
  input  logic [VOL_W-1:0]          master_vol,
  output logic [OUT_W-1:0]          audio_out,
  output logic                      audio_valid,
  output logic                      clip,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Product of an (IN_W+1)-bit signed sample and an unsigned VOL_W volume.
  localparam int PROD_W = IN_W + VOL_W + 1;
  // Headroom for CHANNELS full-scale products, so the running sum never wraps.
  localparam int ACC_W  = IN_W + VOL_W + 1 + $clog2(CHANNELS);
  // Master stage: (acc >>> 3) * master_vol, with room to spare.
  localparam int M_W    = ACC_W + VOL_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_MASTER = 2'd2,
    S_SAT    = 2'd3
  } state_t;

  // Control and output registers (reset)
  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [M_W-1:0]    m_q, m_d;
  logic [OUT_W-1:0]         audio_out_q, audio_out_d;
  logic                     audio_valid_q, audio_valid_d;
  logic                     clip_q, clip_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  // Input snapshot registers (not reset)
  logic [IN_W-1:0]          snap_data_q [CHANNELS];
  logic [IN_W-1:0]          snap_data_d [CHANNELS];
  logic [VOL_W-1:0]         snap_vol_q  [CHANNELS];
  logic [VOL_W-1:0]         snap_vol_d  [CHANNELS];
  logic [CHANNELS-1:0]      snap_signed_q, snap_signed_d;
  logic [CHANNELS-1:0]      snap_mute_q, snap_mute_d;
  logic [VOL_W-1:0]         snap_mvol_q, snap_mvol_d;

  // Datapath intermediates
  logic                     snap_en;
  logic [IN_W-1:0]          cur_data;
  logic [VOL_W-1:0]         cur_vol;
  logic signed [IN_W:0]     ext;
  logic signed [PROD_W-1:0] ext_p, vol_p, prod;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [M_W-1:0]    acc_m, mvol_m;
  logic [M_W-OUT_W:0]       m_top;
  logic                     m_fits;
  logic [OUT_W-1:0]         sat_val;

  // ---------------------------------------------------------------------------
  // Shared MAC datapath: one channel per clock, selected by idx_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_data = snap_data_q[idx_q];
    cur_vol  = snap_vol_q[idx_q];
    ext      = snap_signed_q[idx_q] ? {cur_data[IN_W-1], cur_data}
                                    : {1'b0, cur_data};
    // Both operands are widened to the product width as signed values. The
    // volume is zero-extended, so it is always non-negative.
    ext_p    = PROD_W'(ext);
    vol_p    = PROD_W'(cur_vol);
    prod     = (snap_mute_q[idx_q] || (cur_vol == '0)) ? '0 : ext_p * vol_p;

    // Arithmetic shifts floor toward -infinity, on both sides of the master
    // multiply.
    acc_sh   = acc_q >>> 3;
    acc_m    = M_W'(acc_sh);
    mvol_m   = M_W'(snap_mvol_q);

    // m fits in OUT_W bits iff every bit from the OUT_W-1 position upward
    // equals the sign bit.
    m_top    = m_q[M_W-1:OUT_W-1];
    m_fits   = (m_top == '0) || (m_top == '1);
    if (m_fits) begin
      sat_val = m_q[OUT_W-1:0];
    end else if (m_q[M_W-1]) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    m_d           = m_q;
    audio_out_d   = audio_out_q;
    clip_d        = clip_q;
    audio_valid_d = 1'b0;
    snap_en       = 1'b0;
    // A request seen while a mix is running is dropped and flagged.
    overrun_d     = ce_sample && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ce_sample) begin
          snap_en = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_MASTER;
        end
      end
      S_MASTER: begin
        m_d     = (acc_m * mvol_m) >>> 3;
        state_d = S_SAT;
      end
      S_SAT: begin
        audio_out_d   = sat_val;
        clip_d        = !m_fits;
        audio_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // busy is registered from the next state. It is therefore already low in
    // the audio_valid cycle, so a request arriving in that cycle is accepted.
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    snap_data_d   = snap_data_q;
    snap_vol_d    = snap_vol_q;
    snap_signed_d = snap_signed_q;
    snap_mute_d   = snap_mute_q;
    snap_mvol_d   = snap_mvol_q;
    if (snap_en) begin
      for (int k = 0; k < CHANNELS; k++) begin
        snap_data_d[k] = ch_data[k*IN_W +: IN_W];
        snap_vol_d[k]  = ch_vol[k*VOL_W +: VOL_W];
      end
      snap_signed_d = ch_signed;
      snap_mute_d   = ch_mute;
      snap_mvol_d   = master_vol;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      m_q           <= '0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      clip_q        <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      m_q           <= m_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      clip_q        <= clip_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  // NOTE: the snapshot registers carry no reset. They are always loaded on
  // acceptance before they are read, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    snap_data_q   <= snap_data_d;
    snap_vol_q    <= snap_vol_d;
    snap_signed_q <= snap_signed_d;
    snap_mute_q   <= snap_mute_d;
    snap_mvol_q   <= snap_mvol_d;
  end

  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign clip        = clip_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// -----------------------------------------------------------------------------
// tb_msx_audio_mixer
//
// Bench for msx_audio_mixer with the default parameters (4 channels, 16-bit
// in/out, 4-bit volumes). A table of directed vectors with hand-computed
// results is run one sample at a time. Hand-written sequences then cover
// reset, overrun, back-to-back acceptance and reset during a mix.
// -----------------------------------------------------------------------------
module tb_msx_audio_mixer;

  localparam int CHANNELS = 4;
  localparam int IN_W     = 16;
  localparam int VOL_W    = 4;
  localparam int OUT_W    = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      ce_sample;
  logic [CHANNELS*IN_W-1:0]  ch_data;
  logic [CHANNELS-1:0]       ch_signed;
  logic [CHANNELS*VOL_W-1:0] ch_vol;
  logic [CHANNELS-1:0]       ch_mute;
  logic [VOL_W-1:0]          master_vol;
  logic [OUT_W-1:0]          audio_out;
  logic                      audio_valid;
  logic                      clip;
  logic                      busy;
  logic                      overrun;

  msx_audio_mixer #(
    .CHANNELS (CHANNELS),
    .IN_W     (IN_W),
    .VOL_W    (VOL_W),
    .OUT_W    (OUT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce_sample   (ce_sample),
    .ch_data     (ch_data),
    .ch_signed   (ch_signed),
    .ch_vol      (ch_vol),
    .ch_mute     (ch_mute),
    .master_vol  (master_vol),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .clip        (clip),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;   // {ch3, ch2, ch1, ch0}
    logic [3:0]  sgn;
    logic [15:0] vol;    // {vol3, vol2, vol1, vol0}
    logic [3:0]  mute;
    logic [3:0]  mvol;
    logic [15:0] exp_out;
    logic        exp_clip;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge, when outputs are
  // settled and new inputs can be driven safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    ch_data    = v.data;
    ch_signed  = v.sgn;
    ch_vol     = v.vol;
    ch_mute    = v.mute;
    master_vol = v.mvol;
  endtask

  task automatic scramble();
    ch_data    = {$urandom(), $urandom()};
    ch_signed  = 4'($urandom());
    ch_vol     = 16'($urandom());
    ch_mute    = 4'($urandom());
    master_vol = 4'($urandom());
  endtask

  // Issue one request from IDLE and check its latency, busy window, result and
  // pulse width. Inputs are scrambled right after acceptance, so the result
  // must come from the snapshot.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int busy_cnt;
    logic [15:0] held;
    lat      = 0;
    busy_cnt = 0;
    apply(v);
    ce_sample = 1'b1;
    do begin
      tick();
      ce_sample = 1'b0;
      scramble();
      lat++;
      if (busy) busy_cnt++;
    end while (!audio_valid && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'd7);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd6);
    check({tag, " audio_out"}, 32'(audio_out), 32'(v.exp_out));
    check({tag, " clip"}, 32'(clip), 32'(v.exp_clip));
    held = audio_out;
    tick();
    check({tag, " valid_width"}, 32'(audio_valid), 32'd0);
    check({tag, " out_held"}, 32'(audio_out), 32'(held));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int valid_seen;

    //          data                                         sgn    vol       mute   mvol  out       clip
    vecs[0]  = '{{16'h0000,16'h0000,16'h0000,16'h1000}, 4'hF, 16'h8888, 4'hE, 4'd8,  16'h1000, 1'b0}; // single unity channel
    vecs[1]  = '{{16'h7000,16'h7000,16'h7000,16'h7000}, 4'hF, 16'h8888, 4'h0, 4'd8,  16'h7FFF, 1'b1}; // 0x1C000 -> +clip
    vecs[2]  = '{{16'h7000,16'h7000,16'h7000,16'h0100}, 4'hF, 16'h8888, 4'hE, 4'd8,  16'h0100, 1'b0}; // muted loud channels
    vecs[3]  = '{{16'h0000,16'h0000,16'hA000,16'hA000}, 4'hF, 16'h00FF, 4'h0, 4'd8,  16'h8000, 1'b1}; // -92160 -> -clip
    vecs[4]  = '{{16'h0000,16'h0000,16'hA000,16'hA000}, 4'hF, 16'h00FF, 4'h0, 4'd2,  16'hA600, 1'b0}; // -92160*2/8 = -23040
    vecs[5]  = '{{16'h0000,16'h0000,16'h0000,16'hFFFF}, 4'h0, 16'h0008, 4'h0, 4'd8,  16'h7FFF, 1'b1}; // unsigned 65535
    vecs[6]  = '{{16'h0000,16'h0000,16'h0000,16'hFFFF}, 4'h1, 16'h0008, 4'h0, 4'd8,  16'hFFFF, 1'b0}; // signed -1
    vecs[7]  = '{{16'h0000,16'h0000,16'h0000,16'hFFFF}, 4'h1, 16'h0001, 4'h0, 4'd8,  16'hFFFF, 1'b0}; // -1 >>> 3 floors to -1
    vecs[8]  = '{{16'h0000,16'h0000,16'h0000,16'h0001}, 4'h1, 16'h0001, 4'h0, 4'd8,  16'h0000, 1'b0}; // 1 >>> 3 floors to 0
    vecs[9]  = '{{16'h5555,16'hFF00,16'h0200,16'h0100}, 4'h5, 16'hF8C4, 4'h8, 4'd8,  16'h0280, 1'b0}; // mixed sign/vol/mute
    vecs[10] = '{{16'h0000,16'h0000,16'h0000,16'h7000}, 4'hF, 16'h0000, 4'h0, 4'd8,  16'h0000, 1'b0}; // vol 0
    vecs[11] = '{{16'h7000,16'h7000,16'h7000,16'h7000}, 4'hF, 16'h8888, 4'h0, 4'd0,  16'h0000, 1'b0}; // master 0
    vecs[12] = '{{16'h0000,16'h0000,16'h0000,16'h1000}, 4'h0, 16'h0008, 4'h0, 4'd15, 16'h1E00, 1'b0}; // master 15
    vecs[13] = '{{16'h0000,16'h0000,16'h0000,16'h8000}, 4'h1, 16'h0008, 4'h0, 4'd8,  16'h8000, 1'b0}; // exactly min
    vecs[14] = '{{16'h0000,16'h0000,16'h0000,16'h7FFF}, 4'h1, 16'h0008, 4'h0, 4'd8,  16'h7FFF, 1'b0}; // exactly max
    vecs[15] = '{{16'h0000,16'h0000,16'hFFFF,16'h8000}, 4'h3, 16'h0088, 4'h0, 4'd8,  16'h8000, 1'b1}; // min-1 -> clip

    // Reset for two clocks
    reset     = 1'b1;
    ce_sample = 1'b0;
    apply(vecs[1]);
    tick();
    tick();
    check("rst audio_out", 32'(audio_out), 32'd0);
    check("rst audio_valid", 32'(audio_valid), 32'd0);
    check("rst clip", 32'(clip), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Overrun, back-to-back acceptance, then reset during a mix
    apply(vecs[0]);
    ce_sample = 1'b1;
    tick();                                 // t+1
    ce_sample = 1'b0;
    check("seq busy t+1", 32'(busy), 32'd1);
    tick();                                 // t+2
    tick();                                 // t+3
    ce_sample = 1'b1;                       // dropped: mix in flight
    check("seq overrun t+3", 32'(overrun), 32'd0);
    tick();                                 // t+4
    ce_sample = 1'b0;
    check("seq overrun t+4", 32'(overrun), 32'd1);
    tick();                                 // t+5
    check("seq overrun t+5", 32'(overrun), 32'd0);
    check("seq valid t+5", 32'(audio_valid), 32'd0);
    tick();                                 // t+6
    check("seq valid t+6", 32'(audio_valid), 32'd0);
    tick();                                 // t+7
    check("seq valid t+7", 32'(audio_valid), 32'd1);
    check("seq out t+7", 32'(audio_out), 32'h1000);
    check("seq busy t+7", 32'(busy), 32'd0);
    apply(vecs[5]);
    ce_sample = 1'b1;                       // coincident with valid: accepted
    tick();                                 // t+8
    ce_sample = 1'b0;
    check("seq busy t+8", 32'(busy), 32'd1);
    check("seq overrun t+8", 32'(overrun), 32'd0);
    tick();                                 // t+9
    reset = 1'b1;
    tick();                                 // t+10
    reset = 1'b0;
    check("seq rst out", 32'(audio_out), 32'd0);
    check("seq rst busy", 32'(busy), 32'd0);
    check("seq rst clip", 32'(clip), 32'd0);
    valid_seen = 0;
    for (int c = 0; c < 8; c++) begin       // t+11 .. t+18, spans t+14
      tick();
      if (audio_valid) valid_seen++;
    end
    check("seq aborted valid", 32'(valid_seen), 32'd0);
    check("seq aborted out", 32'(audio_out), 32'd0);

    // Recovery after an aborted mix
    run_vec(vecs[9], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
